// File: rtl/audio_pkg.sv
// Shared constants and types for the WM8731 ADC capture path.
package audio_pkg;

  localparam int DATA_W_DEF = 16;
  localparam logic LRCK_LEFT = 1'b0;

  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, HOLD} rx_state_e;

  function automatic int cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_w(DATA_W_DEF);

endpackage

// File: rtl/audio_adc_rx_bit_sync.sv
// Two-flop synchroniser for a slow codec pin, plus one delay stage
// so that rising and any-edge events can be produced in the clk_50 domain.
module bit_sync (
  input  logic clk_50,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic edge_o
);

  logic ff1_q, ff2_q, dly_q;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
      dly_q <= 1'b0;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
      dly_q <= ff2_q;
    end
  end

  assign q_o    = ff2_q;
  assign rise_o = ff2_q & ~dly_q;
  assign edge_o = ff2_q ^ dly_q;

endmodule

// File: rtl/audio_adc_rx.sv
// WM8731 ADC capture: deserialises AUD_ADCDAT into left/right PCM pairs
// (I2S or left-justified) and hands them out over valid/ready.
module audio_adc_rx
  import audio_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter bit I2S_MODE = 1'b1
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              aud_bclk,
  input  logic              aud_adclrck,
  input  logic              aud_adcdat,
  output logic [DATA_W-1:0] out_left,
  output logic [DATA_W-1:0] out_right,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              frame_err
);

  localparam int CW = cnt_w(DATA_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  logic rst_meta_q, rst_sync_q;

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  logic bclk_s, bclk_rise, bclk_edge_unused;
  logic lrck_s, lrck_rise_unused, lrck_edge_unused;
  logic dat_ff1_q, dat_s;

  bit_sync u_bclk_sync (
    .clk_50 (clk_50),
    .rst_n  (rst_sync_q),
    .d_i    (aud_bclk),
    .q_o    (bclk_s),
    .rise_o (bclk_rise),
    .edge_o (bclk_edge_unused)
  );

  bit_sync u_lrck_sync (
    .clk_50 (clk_50),
    .rst_n  (rst_sync_q),
    .d_i    (aud_adclrck),
    .q_o    (lrck_s),
    .rise_o (lrck_rise_unused),
    .edge_o (lrck_edge_unused)
  );

  always_ff @(posedge clk_50 or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      dat_ff1_q <= 1'b0;
      dat_s     <= 1'b0;
    end else begin
      dat_ff1_q <= aud_adcdat;
      dat_s     <= dat_ff1_q;
    end
  end

  rx_state_e         state_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] shift_q, left_word_q, out_left_q, out_right_q;
  logic              slot_lr_q, lrck_bit_q, left_ok_q;
  logic              valid_q, overrun_q, ferr_q;
  logic [DATA_W-1:0] word_in;
  logic              lrck_chg, slot_start;

  // LRCK is judged only against its level at the previous BCLK rise.
  assign lrck_chg   = bclk_s & bclk_rise & (lrck_s ^ lrck_bit_q);
  assign slot_start = lrck_chg & ((state_q != IDLE) | (lrck_s == LRCK_LEFT));
  assign word_in    = {shift_q[DATA_W-2:0], dat_s};

  always_ff @(posedge clk_50 or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      slot_lr_q   <= LRCK_LEFT;
      lrck_bit_q  <= 1'b0;
      left_ok_q   <= 1'b0;
      left_word_q <= '0;
      out_left_q  <= '0;
      out_right_q <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
      if (valid_q && out_ready) valid_q <= 1'b0;
      if (bclk_rise) lrck_bit_q <= lrck_s;

      if (slot_start) begin
        ferr_q    <= (state_q == SHIFT);
        slot_lr_q <= lrck_s;
        if ((state_q == SHIFT) || (lrck_s == LRCK_LEFT)) left_ok_q <= 1'b0;
        // The edge BCLK is the I2S delay bit, but the MSB in left-justified mode.
        shift_q   <= I2S_MODE ? '0 : {{(DATA_W-1){1'b0}}, dat_s};
        cnt_q     <= I2S_MODE ? '0 : CW'(1);
        state_q   <= I2S_MODE ? SKIP : SHIFT;
      end else begin
        case (state_q)
          SKIP: state_q <= SHIFT;
          SHIFT: begin
            if (bclk_rise) begin
              shift_q <= word_in;
              cnt_q   <= cnt_q + CW'(1);
              if (cnt_q == LAST_BIT) begin
                state_q <= HOLD;
                if (slot_lr_q == LRCK_LEFT) begin
                  left_word_q <= word_in;
                  left_ok_q   <= 1'b1;
                end else if (left_ok_q) begin
                  left_ok_q   <= 1'b0;
                  out_left_q  <= left_word_q;
                  out_right_q <= word_in;
                  valid_q     <= 1'b1;
                  overrun_q   <= valid_q & ~out_ready;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign out_left  = out_left_q;
  assign out_right = out_right_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_audio_adc_rx.sv
// Bench for audio_adc_rx: one I2S and one left-justified instance fed from
// the same BCLK/LRCK, with a pair scoreboard per instance.
module tb_audio_adc_rx;

  localparam int W = 16;

  logic clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  logic         reset, aud_bclk, aud_adclrck, dat_i2s, dat_lj, out_ready;
  logic [W-1:0] left_a, right_a, left_b, right_b;
  logic         valid_a, valid_b, ovr_a, ovr_b, ferr_a, ferr_b;

  audio_adc_rx #(.DATA_W(W), .I2S_MODE(1'b1)) dut_i2s (
    .clk_50      (clk_50),
    .reset       (reset),
    .aud_bclk    (aud_bclk),
    .aud_adclrck (aud_adclrck),
    .aud_adcdat  (dat_i2s),
    .out_left    (left_a),
    .out_right   (right_a),
    .out_valid   (valid_a),
    .out_ready   (out_ready),
    .overrun     (ovr_a),
    .frame_err   (ferr_a)
  );

  audio_adc_rx #(.DATA_W(W), .I2S_MODE(1'b0)) dut_lj (
    .clk_50      (clk_50),
    .reset       (reset),
    .aud_bclk    (aud_bclk),
    .aud_adclrck (aud_adclrck),
    .aud_adcdat  (dat_lj),
    .out_left    (left_b),
    .out_right   (right_b),
    .out_valid   (valid_b),
    .out_ready   (out_ready),
    .overrun     (ovr_b),
    .frame_err   (ferr_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ovr_n[2]  = '{0, 0};
  int ferr_n[2] = '{0, 0};
  int acc_n[2]  = '{0, 0};
  logic [2*W-1:0] exp_a[$];
  logic [2*W-1:0] exp_b[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic take(input int idx, input logic [31:0] got);
    logic [31:0] e;
    acc_n[idx]++;
    if (idx == 0) begin
      if (exp_a.size() == 0) chk("pair_i2s_extra", 32'(exp_a.size()), 1);
      else begin
        e = exp_a.pop_front();
        chk("pair_i2s", got, e);
      end
    end else begin
      if (exp_b.size() == 0) chk("pair_lj_extra", 32'(exp_b.size()), 1);
      else begin
        e = exp_b.pop_front();
        chk("pair_lj", got, e);
      end
    end
  endtask

  always @(negedge clk_50) begin
    if (ovr_a) ovr_n[0]++;
    if (ovr_b) ovr_n[1]++;
    if (ferr_a) ferr_n[0]++;
    if (ferr_b) ferr_n[1]++;
    if (valid_a && out_ready) take(0, {left_a, right_a});
    if (valid_b && out_ready) take(1, {left_b, right_b});
  end

  task automatic expect_pair(input logic [W-1:0] l, input logic [W-1:0] r);
    exp_a.push_back({l, r});
    exp_b.push_back({l, r});
  endtask

  // BCLK period = 12 clk_50 cycles; LRCK and data change on the falling edge.
  task automatic bclk_bit(input logic lr, input logic bi, input logic bl);
    aud_bclk    = 1'b0;
    aud_adclrck = lr;
    dat_i2s     = bi;
    dat_lj      = bl;
    repeat (6) @(posedge clk_50);
    aud_bclk = 1'b1;
    repeat (6) @(posedge clk_50);
  endtask

  task automatic send_slot(input logic lr, input logic [W-1:0] w, input int nb);
    logic bi, bl;
    for (int k = 0; k < nb; k++) begin
      if (k == 0) bi = 1'b1;
      else if (k <= W) bi = w[W-k];
      else bi = 1'b0;
      bl = (k < W) ? w[W-1-k] : 1'b0;
      bclk_bit(lr, bi, bl);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r);
    send_slot(1'b0, l, 32);
    send_slot(1'b1, r, 32);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_left_i2s"},  32'(left_a),  0);
    chk({tag, "_right_i2s"}, 32'(right_a), 0);
    chk({tag, "_valid_i2s"}, 32'(valid_a), 0);
    chk({tag, "_ovr_i2s"},   32'(ovr_a),   0);
    chk({tag, "_ferr_i2s"},  32'(ferr_a),  0);
    chk({tag, "_left_lj"},   32'(left_b),  0);
    chk({tag, "_right_lj"},  32'(right_b), 0);
    chk({tag, "_valid_lj"},  32'(valid_b), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int o0, o1, f0, f1, a0, a1;
    reset = 1'b1; aud_bclk = 1'b0; aud_adclrck = 1'b1;
    dat_i2s = 1'b0; dat_lj = 1'b0; out_ready = 1'b1;
    #5 reset = 1'b0;
    repeat (5) @(posedge clk_50);
    #1 chk_idle_outputs("reset");
    reset = 1'b1;
    repeat (4) @(posedge clk_50);
    send_slot(1'b1, 16'h0000, 4);

    // basic I2S / LJ streaming
    o0 = ovr_n[0]; o1 = ovr_n[1]; f0 = ferr_n[0]; f1 = ferr_n[1];
    a0 = acc_n[0]; a1 = acc_n[1];
    for (int i = 0; i < 3; i++) begin
      expect_pair(16'hA5C3, 16'h5A3C);
      send_frame(16'hA5C3, 16'h5A3C);
    end
    chk("basic_acc_i2s", 32'(acc_n[0] - a0), 3);
    chk("basic_acc_lj",  32'(acc_n[1] - a1), 3);
    chk("basic_ovr_i2s", 32'(ovr_n[0] - o0), 0);
    chk("basic_ferr_i2s", 32'(ferr_n[0] - f0), 0);
    chk("basic_ferr_lj",  32'(ferr_n[1] - f1), 0);

    // backpressure: second pair overwrites the first
    o0 = ovr_n[0]; o1 = ovr_n[1];
    out_ready = 1'b0;
    send_frame(16'h1111, 16'h2222);
    expect_pair(16'h3333, 16'h4444);
    send_frame(16'h3333, 16'h4444);
    #1;
    chk("bp_ovr_i2s", 32'(ovr_n[0] - o0), 1);
    chk("bp_ovr_lj",  32'(ovr_n[1] - o1), 1);
    chk("bp_hold_valid_i2s", 32'(valid_a), 1);
    chk("bp_hold_left_i2s",  32'(left_a), 32'h3333);
    out_ready = 1'b1;
    repeat (4) @(posedge clk_50);
    #1;
    chk("bp_drop_valid_i2s", 32'(valid_a), 0);
    chk("bp_drop_valid_lj",  32'(valid_b), 0);
    chk("bp_q_i2s", 32'(exp_a.size()), 0);
    chk("bp_q_lj",  32'(exp_b.size()), 0);

    // short left slot
    f0 = ferr_n[0]; f1 = ferr_n[1]; a0 = acc_n[0]; a1 = acc_n[1];
    send_slot(1'b0, 16'h1234, 11);
    send_slot(1'b1, 16'h5678, 32);
    expect_pair(16'h7FFF, 16'h8000);
    send_frame(16'h7FFF, 16'h8000);
    chk("short_ferr_i2s", 32'(ferr_n[0] - f0), 1);
    chk("short_ferr_lj",  32'(ferr_n[1] - f1), 1);
    chk("short_acc_i2s",  32'(acc_n[0] - a0), 1);
    chk("short_acc_lj",   32'(acc_n[1] - a1), 1);

    // alignment corner values
    expect_pair(16'h8001, 16'h0001);
    send_frame(16'h8001, 16'h0001);
    chk("lj_q_lj",  32'(exp_b.size()), 0);
    chk("lj_q_i2s", 32'(exp_a.size()), 0);

    // reset in the right word, release inside the right slot
    send_slot(1'b0, 16'hBEEF, 32);
    send_slot(1'b1, 16'hCAFE, 8);
    reset = 1'b0;
    #1 chk_idle_outputs("midreset");
    repeat (10) @(posedge clk_50);
    reset = 1'b1;
    f0 = ferr_n[0]; f1 = ferr_n[1]; a0 = acc_n[0]; a1 = acc_n[1];
    send_slot(1'b1, 16'hCAFE, 24);
    chk("rst_noout_i2s", 32'(acc_n[0] - a0), 0);
    chk("rst_noout_lj",  32'(acc_n[1] - a1), 0);
    expect_pair(16'h0F0F, 16'hF0F0);
    send_frame(16'h0F0F, 16'hF0F0);
    chk("rst_acc_i2s",  32'(acc_n[0] - a0), 1);
    chk("rst_acc_lj",   32'(acc_n[1] - a1), 1);
    chk("rst_ferr_i2s", 32'(ferr_n[0] - f0), 0);
    chk("rst_ferr_lj",  32'(ferr_n[1] - f1), 0);

    repeat (10) @(posedge clk_50);
    chk("end_q_i2s", 32'(exp_a.size()), 0);
    chk("end_q_lj",  32'(exp_b.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/audio_adc_rx.md
Name: audio_adc_rx

Overview:
- Capture side of the WM8731 codec link: deserialises AUD_ADCDAT into parallel left/right PCM samples for the drum core.
- Complements the existing DAC output path. AUD_BCLK and AUD_ADCLRCK are generated elsewhere (FPGA is clock master) and arrive here as plain inputs.
- Oversamples all codec pins in the clk_50 domain. Delivers one stereo pair per LRCK frame through a valid/ready interface with overrun and framing error flags.

Parameters:
- DATA_W, 16: bits per channel word, MSB first.
- I2S_MODE, 1: 1 = I2S format (one BCLK delay after each LRCK edge); 0 = left-justified (MSB on first BCLK after the edge).

Ports:
- clk_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- aud_bclk  in  1  codec bit clock, asynchronous to clk_50.
- aud_adclrck  in  1  ADC frame clock; 0 = left channel, 1 = right channel.
- aud_adcdat  in  1  ADC serial data.
- out_left  out  DATA_W  left sample, two's complement.
- out_right  out  DATA_W  right sample, two's complement.
- out_valid  out  1  pair available; held until accepted.
- out_ready  in  1  consumer accepts the pair when out_valid & out_ready.
- overrun  out  1  1-cycle pulse: an unaccepted pair was overwritten.
- frame_err  out  1  1-cycle pulse: channel slot ended before DATA_W bits were received.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM to IDLE, shift register and bit counter cleared.
- Reset mid-word discards the partial word. No output until a fresh left slot starts.
- Synchronisation: all three pins pass through a 2-FF synchroniser.
- Bit timing: a BCLK rising edge is detected as ff2 & ~ff2_d. Data is sampled in the clk_50 cycle where that edge is detected.
- LRCK edges are also evaluated only on detected BCLK rising edges.
- Requirement: each BCLK half-period is at least 2 clk_50 cycles.
- FSM states: IDLE, SKIP, SHIFT, HOLD.
  - IDLE: wait for an LRCK 1->0 edge, so capture always starts on a left slot. On the edge go to SKIP if I2S_MODE=1, else SHIFT; the edge bit counts as bit 0 in left-justified mode.
  - SKIP: consume one BCLK, then go to SHIFT.
  - SHIFT: shift in MSB first; bit counter counts 0..DATA_W-1.
    - At DATA_W bits the channel word is latched (left or right, per LRCK level at the slot start); go to HOLD.
    - If an LRCK edge arrives before the count completes: frame_err pulses, the current frame's pair is dropped, and the new slot is started from the edge (SKIP or SHIFT, same rule as IDLE).
  - HOLD: ignore extra slot bits. On an LRCK edge, start the next slot (SKIP or SHIFT).
- Pair completion: completing the right word after a good left word in the same frame loads out_left/out_right and sets out_valid.
  - out_valid rises at most 4 clk_50 cycles after the physical BCLK edge carrying the right LSB.
- Handshake:
  - out_valid stays high with stable data until out_ready is seen.
  - Load while out_valid=1 and out_ready=0: the newest pair overwrites, overrun pulses, and out_valid stays 1.
  - Load in the same cycle as acceptance: no overrun, and out_valid stays 1 with the new data.
- Width rule: words are captured verbatim, with no sign extension or truncation inside the block.

Decomposition:
- Shared package audio_pkg holds:
  - DATA_W default;
  - the FSM state enum {IDLE, SKIP, SHIFT, HOLD};
  - LRCK_LEFT constant (1'b0);
  - bit counter width clog2(DATA_W+1).
- Sub-module bit_sync: 2-FF synchroniser plus one delay stage with rising/any-edge outputs.
  - Instantiated for BCLK and LRCK.
  - DATA uses the 2-FF synchroniser only.

Test Plan:
- Basic I2S: BCLK = 12 clk_50 periods, 32-bit slots, left=16'hA5C3, right=16'h5A3C, out_ready=1 -> out_valid pulses once per frame with out_left=A5C3, out_right=5A3C; overrun=0, frame_err=0.
- Backpressure: out_ready=0 for frames carrying (1111,2222), then (3333,4444) -> overrun pulses once at the second load. After out_ready rises, out_left=3333 and out_right=4444 are accepted, then out_valid falls.
- Short slot: LRCK toggles after 10 bits of the left word -> frame_err pulses once and no out_valid for that frame. The next full frame (7FFF,8000) is delivered correctly.
- Left-justified: I2S_MODE=0, left=16'h8001, right=16'h0001 -> outputs exactly 8001/0001, with no 1-bit shift.
- Reset mid-operation: drive reset low at bit 7 of the right word -> all outputs 0 immediately. After release, no output until the next full frame, which is captured correctly.
- Startup alignment: release reset in the middle of a right slot -> the first pair is delivered only after a complete left+right frame; no frame_err.
